// File: rtl/tick_pkg.sv
// Shared definitions for the tick generators and the tick period checker.
// Holds the checker state encoding, the default divider constants and a
// helper that sizes the good-interval counter.
package tick_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } tick_state_t;

  localparam int TICK_EXPECTED = 500;
  localparam int TICK_TOL      = 2;
  localparam int TICK_LOCK_CNT = 4;
  localparam int TICK_WIDTH    = 14;

  // Bits needed to hold 0..lock_cnt.
  function automatic int good_width(input int lock_cnt);
    return (lock_cnt < 2) ? 1 : $clog2(lock_cnt + 1);
  endfunction

endpackage

// File: rtl/tick_interval_counter.sv
// Interval counter for the tick period checker.
// Ports:
//   clk, reset   - clock, asynchronous active-high reset
//   tick         - strobe; clears the counter when high
//   meas         - cnt+1, the interval a tick sampled this cycle would measure
//   in_window    - meas lies inside EXPECTED +/- TOL
//   overdue      - no tick this cycle and the last acceptable slot has passed
module tick_interval_counter #(
  parameter int EXPECTED = 500,
  parameter int TOL      = 2,
  parameter int WIDTH    = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  output logic [WIDTH-1:0] meas,
  output logic             in_window,
  output logic             overdue
);

  localparam logic [WIDTH-1:0] LO   = WIDTH'(EXPECTED - TOL);
  localparam logic [WIDTH-1:0] HI   = WIDTH'(EXPECTED + TOL);
  localparam logic [WIDTH-1:0] LAST = WIDTH'(EXPECTED + TOL - 1);

  logic [WIDTH-1:0] cnt;

  // Free-runs in IDLE too; any wrap there is harmless because IDLE ignores it,
  // and outside IDLE the timeout stops the interval before cnt passes LAST.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + WIDTH'(1);
    end
  end

  assign meas      = cnt + WIDTH'(1);
  assign in_window = (meas >= LO) && (meas <= HI);
  assign overdue   = !tick && (cnt == LAST);

endmodule

// File: rtl/tick_period_checker.sv
// Tick period checker: measures the interval between tick_in strobes,
// declares lock after LOCK_CNT consecutive in-window intervals, and flags
// short intervals (err) and missing ticks (timeout).
// Ports:
//   clk, reset    - clock, asynchronous active-high reset
//   tick_in       - single-cycle strobe under test (every high cycle is a tick)
//   period        - last measured interval in clk cycles
//   period_valid  - one-cycle pulse when period updates
//   locked        - high while the FSM is in LOCKED
//   err           - one-cycle pulse on an out-of-window (short) interval
//   timeout       - one-cycle pulse when a tick is overdue
// The FSM state is kept in the plain signal 'state' for checkers to bind to.
module tick_period_checker
  import tick_pkg::*;
#(
  parameter int EXPECTED = TICK_EXPECTED,
  parameter int TOL      = TICK_TOL,
  parameter int LOCK_CNT = TICK_LOCK_CNT,
  parameter int WIDTH    = TICK_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_in,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             err,
  output logic             timeout
);

  localparam int              GW       = good_width(LOCK_CNT);
  localparam logic [GW-1:0]   GOOD_MAX = GW'(LOCK_CNT);

  tick_state_t      state, state_next;
  logic [GW-1:0]    good, good_next;
  logic [WIDTH-1:0] period_next;
  logic             pv_next, err_next, timeout_next;

  logic [WIDTH-1:0] meas;
  logic             in_window, overdue;

  tick_interval_counter #(
    .EXPECTED (EXPECTED),
    .TOL      (TOL),
    .WIDTH    (WIDTH)
  ) u_cnt (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick_in),
    .meas      (meas),
    .in_window (in_window),
    .overdue   (overdue)
  );

  always_comb begin
    state_next   = state;
    good_next    = good;
    period_next  = period;
    pv_next      = 1'b0;
    err_next     = 1'b0;
    timeout_next = 1'b0;
    case (state)
      IDLE: begin
        // First tick has no predecessor, so nothing is measured.
        if (tick_in) begin
          state_next = ACQ;
          good_next  = '0;
        end
      end
      ACQ, LOCKED: begin
        if (tick_in) begin
          period_next = meas;
          pv_next     = 1'b1;
          if (in_window) begin
            if (state == ACQ) begin
              good_next = good + GW'(1);
              if (good + GW'(1) == GOOD_MAX) state_next = LOCKED;
            end
          end else begin
            err_next   = 1'b1;
            good_next  = '0;
            state_next = ACQ;
          end
        end else if (overdue) begin
          // Long intervals end here, so they never reach the err path.
          timeout_next = 1'b1;
          good_next    = '0;
          state_next   = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        good_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      good         <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      err          <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state        <= state_next;
      good         <= good_next;
      period       <= period_next;
      period_valid <= pv_next;
      locked       <= (state_next == LOCKED);
      err          <= err_next;
      timeout      <= timeout_next;
    end
  end

endmodule

// File: tb/tb_tick_period_checker.sv
// Bench for tick_period_checker with default parameters.
// Pulse outputs are checked by a scoreboard: each expected event
// {period_valid, err, timeout, period} is queued when the tick that causes it
// is driven, and popped whenever the DUT raises any pulse output.
module tb_tick_period_checker;
  import tick_pkg::*;

  localparam int W  = TICK_WIDTH;
  localparam int EW = 3 + W;

  logic         clk = 1'b0;
  logic         reset;
  logic         tick_in;
  logic [W-1:0] period;
  logic         period_valid, locked, err, timeout;

  int total = 0;
  int bad   = 0;

  logic [EW-1:0] exp_q[$];
  logic [W-1:0]  held_period;

  typedef struct {
    int           gap;
    logic         pv;
    logic         er;
    logic [W-1:0] per;
    logic         lk;
  } row_t;

  row_t rows[0:31];
  int   nrows = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
    $fatal(1, "watchdog");
  end

  tick_period_checker #(
    .EXPECTED (TICK_EXPECTED),
    .TOL      (TICK_TOL),
    .LOCK_CNT (TICK_LOCK_CNT),
    .WIDTH    (TICK_WIDTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .tick_in      (tick_in),
    .period       (period),
    .period_valid (period_valid),
    .locked       (locked),
    .err          (err),
    .timeout      (timeout)
  );

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: any pulse output must match the head of the expected queue.
  always @(negedge clk) begin
    if (period_valid || err || timeout) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: got pv=%0b err=%0b to=%0b period=%0d, required none at %0t",
                 period_valid, err, timeout, period, $time);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        chk("event{pv,err,to,period}", 32'({period_valid, err, timeout, period}), 32'(e));
      end
    end
  end

  // ---------------- driver ----------------
  // Entered anywhere in the cycle after the edge that sampled the previous
  // tick (edge T0); makes the next tick sampled at edge T0+gap and returns at
  // the falling edge after it.
  task automatic send_tick(input int gap);
    repeat (gap - 1) @(posedge clk);
    #1 tick_in = 1'b1;
    @(posedge clk);
    #1 tick_in = 1'b0;
    @(negedge clk);
  endtask

  task automatic add_row(input int gap, input logic pv, input logic er,
                         input int per, input logic lk);
    rows[nrows].gap = gap;
    rows[nrows].pv  = pv;
    rows[nrows].er  = er;
    rows[nrows].per = W'(per);
    rows[nrows].lk  = lk;
    nrows++;
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      if (rows[i].pv) begin
        exp_q.push_back({1'b1, rows[i].er, 1'b0, rows[i].per});
        held_period = rows[i].per;
      end
      send_tick(rows[i].gap);
      chk($sformatf("locked_row%0d", i), 32'(locked), 32'(rows[i].lk));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset       = 1'b1;
    tick_in     = 1'b0;
    held_period = '0;

    // Rows 0-5: first tick from IDLE, then 500-cycle ticks until lock.
    add_row(7,   0, 0, 0,   0);
    add_row(500, 1, 0, 500, 0);
    add_row(500, 1, 0, 500, 0);
    add_row(500, 1, 0, 500, 0);
    add_row(500, 1, 0, 500, 1);
    add_row(500, 1, 0, 500, 1);
    // Rows 6-10: short interval drops lock, four good ones regain it.
    add_row(497, 1, 1, 497, 0);
    add_row(500, 1, 0, 500, 0);
    add_row(500, 1, 0, 500, 0);
    add_row(500, 1, 0, 500, 0);
    add_row(500, 1, 0, 500, 1);
    // Rows 11-12: window edges accepted.
    add_row(498, 1, 0, 498, 1);
    add_row(502, 1, 0, 502, 1);
    // Rows 13-18: after timeout+IDLE tick, adjacent ticks in ACQ clear good.
    add_row(500, 1, 0, 500, 0);
    add_row(1,   1, 1, 1,   0);
    add_row(500, 1, 0, 500, 0);
    add_row(500, 1, 0, 500, 0);
    add_row(500, 1, 0, 500, 0);
    add_row(500, 1, 0, 500, 1);
    // Rows 19-24: tick held high two cycles while locked, then relock.
    add_row(1,   1, 1, 1,   0);
    add_row(1,   1, 1, 1,   0);
    add_row(500, 1, 0, 500, 0);
    add_row(500, 1, 0, 500, 0);
    add_row(500, 1, 0, 500, 0);
    add_row(500, 1, 0, 500, 1);
    // Rows 25-26: after mid-interval reset.
    add_row(9,   0, 0, 0,   0);
    add_row(500, 1, 0, 500, 0);

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_period",  32'(period),       32'd0);
    chk("rst_pv",      32'(period_valid), 32'd0);
    chk("rst_locked",  32'(locked),       32'd0);
    chk("rst_err",     32'(err),          32'd0);
    chk("rst_timeout", 32'(timeout),      32'd0);
    chk("rst_state",   32'(dut.state),    32'(IDLE));
    reset = 1'b0;

    run_rows(0, 12);

    // Locked, next tick withheld: timeout after the edge following cnt=501.
    exp_q.push_back({1'b0, 1'b0, 1'b1, held_period});
    repeat (501) @(posedge clk);
    @(negedge clk);
    chk("timeout_early", 32'(timeout), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("timeout_pulse",  32'(timeout),   32'd1);
    chk("timeout_locked", 32'(locked),    32'd0);
    chk("timeout_state",  32'(dut.state), 32'(IDLE));
    chk("timeout_period", 32'(period),    32'd502);
    // Tick at interval 503 lands in IDLE: no period_valid.
    #1 tick_in = 1'b1;
    @(posedge clk);
    #1 tick_in = 1'b0;
    @(negedge clk);
    chk("idle_tick_pv", 32'(period_valid), 32'd0);

    run_rows(13, 24);

    // Reset asserted for 3 cycles while locked, mid-interval.
    repeat (100) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_async_locked", 32'(locked), 32'd0);
    chk("midrst_async_period", 32'(period), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("midrst_outputs", 32'({period, period_valid, locked, err, timeout}), 32'd0);
    reset = 1'b0;

    run_rows(25, 26);

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("events_outstanding", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tick_period_checker.md
# tick_period_checker

Consumer-side monitor for the single-cycle strobe produced by the design's clock-divider tick generators. Measures the clk-cycle interval between successive `tick_in` pulses and compares it against an expected period with tolerance. Declares lock after a run of good intervals and flags short intervals (`err`) and missing ticks (`timeout`). Used to verify divider health before timer, display or UART logic trusts the tick.

## Interface
Parameters:
- `EXPECTED`, default 500: nominal interval in clk cycles.
- `TOL`, default 2: accepted deviation, ± cycles; constraint `TOL < EXPECTED`.
- `LOCK_CNT`, default 4: consecutive good intervals required for lock; ≥ 1.
- `WIDTH`, default 14: counter/period width; constraint `EXPECTED+TOL < 2**WIDTH`.

Ports:
- `clk` in 1: single clock; all logic on posedge.
- `reset` in 1: asynchronous, active-high; clears all state and outputs immediately.
- `tick_in` in 1: strobe. Every cycle it is sampled high counts as one tick.
- `period` out WIDTH: last measured interval.
- `period_valid` out 1: one-cycle pulse when `period` updates.
- `locked` out 1: level, high while in LOCKED.
- `err` out 1: one-cycle pulse on an out-of-window interval.
- `timeout` out 1: one-cycle pulse when a tick is overdue.

## Operation
- Interval counter `cnt`:
  - Cleared to 0 on any tick.
  - Otherwise increments each cycle.
  - Measured interval is `cnt+1`, so ticks 500 cycles apart measure 500.
- Window: `EXPECTED-TOL ≤ cnt+1 ≤ EXPECTED+TOL`.
- Good-interval counter `good`: range 0..LOCK_CNT.
- States:
  - IDLE (reset state):
    - `cnt` is ignored.
    - Tick → ACQ, `cnt`=0, `good`=0. No `period_valid`, since there is no prior tick.
  - ACQ:
    - Tick in window: `period`←`cnt+1`, `period_valid` pulse, `good`++.
    - If `good` reaches LOCK_CNT → LOCKED.
    - Tick out of window: `period` updated, `period_valid` and `err` pulse, `good`←0, stay in ACQ.
  - LOCKED:
    - Tick in window: `period` updated, `period_valid` pulse, stay.
    - Tick out of window: `period` updated, `period_valid` and `err` pulse, `good`←0 → ACQ.
  - Timeout (ACQ or LOCKED):
    - Condition: `tick_in`=0 and `cnt == EXPECTED+TOL-1`, meaning the last acceptable tick slot has passed.
    - Action: `timeout` pulse → IDLE, `good`←0.
    - `period` is not updated.
- Consequences:
  - `cnt` never exceeds EXPECTED+TOL-1 outside IDLE, so no overflow handling is required.
  - Long intervals always surface as `timeout`, never as `err`.
- Short intervals, including back-to-back ticks (interval 1), produce `err`. `tick_in` held high gives `err` every cycle from the second tick on.
- A tick arriving in the same cycle as the timeout condition cannot occur, because a tick takes precedence and the timeout condition requires `tick_in`=0.

## Timing
- All outputs are registered. A response to a tick or timeout sampled at edge N is visible after edge N+1.
- Pulse outputs are high for exactly one cycle.
- `locked` rises one cycle after the LOCK_CNT-th good tick, which is the (LOCK_CNT+1)-th tick overall after IDLE.
- `locked` falls one cycle after an `err`-causing tick or after the timeout condition.
- Reset values:
  - `period`=0, `period_valid`=0, `locked`=0, `err`=0, `timeout`=0.
  - State IDLE, `cnt`=0, `good`=0.
- Reset asserted mid-interval: outputs clear asynchronously. After release, the first tick is treated as an IDLE tick.

## Structure
- Shared package `tick_pkg` holds:
  - The state encoding (IDLE/ACQ/LOCKED, 2 bits).
  - Default constants `TICK_EXPECTED=500`, `TICK_TOL=2`, `TICK_LOCK_CNT=4`, `TICK_WIDTH=14`, shared with the divider instances.
- Sub-module `tick_interval_counter`:
  - Contains `cnt`, with clear-on-tick and increment.
  - Outputs `cnt+1` plus `in_window` and `overdue` flags.
- Top level holds the FSM, `good` counter and output registers.

## Test plan
- Reset, then ticks every 500 cycles ×6:
  - `period_valid` pulses with `period`=500 from the 2nd tick onward.
  - `locked` rises 1 cycle after the 5th tick.
  - `err`/`timeout` stay 0.
- Locked, then one interval of 497:
  - `err` pulse, `period`=497, `locked` drops the next cycle.
  - Four further 500-cycle intervals re-assert `locked`.
- Locked, intervals 498 and 502:
  - Both are accepted with no `err`.
- Locked, next tick withheld:
  - `timeout` pulses one cycle after the edge where `cnt`=501.
  - `locked`→0, state IDLE.
  - A tick at interval 503 produces no `period_valid`.
- ACQ, two adjacent ticks:
  - `err` pulse with `period`=1.
  - `good` cleared, so four fresh good intervals are needed to lock.
- Reset asserted for 3 cycles while locked mid-interval:
  - All outputs 0 during reset.
  - The first post-reset tick gives no `period_valid`.
  - The second tick, 500 cycles later, gives `period`=500.
